// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier with signed/unsigned mode and add/sub operation counters.
// Optional early termination is compiled in with `define BOOTH_EARLY_TERM_EN.
module booth_radix4_mul #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW = $clog2(WIDTH / 2 + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mtpr,
    input  logic [WIDTH-1:0]     mtpd,
    output logic                 done,
    output logic [CW-1:0]        adds,
    output logic [CW-1:0]        subs,
    output logic [2*WIDTH-1:0]   prod
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [CW-1:0] LastSigned   = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LastUnsigned = CW'(WIDTH / 2);

    state_e             state_q, state_d;
    logic [WIDTH+2:0]   q_q, q_d, q_shift;
    logic [2*WIDTH-1:0] m_q, m_d, prod_q, prod_d;
    logic [CW-1:0]      adds_q, adds_d, subs_q, subs_d, cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic               ext, last_step, early;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        m_d      = m_q;
        prod_d   = prod_q;
        adds_d   = adds_q;
        subs_d   = subs_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        ext      = signed_mode & mtpr[WIDTH-1];

        q_shift   = {{2{q_q[WIDTH+2]}}, q_q[WIDTH+2:2]};
        last_step = (cnt_q == (signed_q ? LastSigned : LastUnsigned));
`ifdef BOOTH_EARLY_TERM_EN
        // Uniform remaining bits only yield 000/111 windows, i.e. no-ops.
        early = (q_shift == '0) || (q_shift == '1);
`else
        early = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_d      = {ext, ext, mtpr, 1'b0};
                    m_d      = signed_mode ? {{WIDTH{mtpd[WIDTH-1]}}, mtpd}
                                           : {{WIDTH{1'b0}}, mtpd};
                    prod_d   = '0;
                    adds_d   = '0;
                    subs_d   = '0;
                    cnt_d    = '0;
                    signed_d = signed_mode;
                    state_d  = StRun;
                end
            end
            StRun: begin
                case (q_q[2:0])
                    3'b001, 3'b010: begin
                        prod_d = prod_q + m_q;
                        adds_d = adds_q + 1'b1;
                    end
                    3'b011: begin
                        prod_d = prod_q + {m_q[2*WIDTH-2:0], 1'b0};
                        adds_d = adds_q + 1'b1;
                    end
                    3'b100: begin
                        prod_d = prod_q - {m_q[2*WIDTH-2:0], 1'b0};
                        subs_d = subs_q + 1'b1;
                    end
                    3'b101, 3'b110: begin
                        prod_d = prod_q - m_q;
                        subs_d = subs_q + 1'b1;
                    end
                    default: ;
                endcase
                q_d   = q_shift;
                m_d   = {m_q[2*WIDTH-3:0], 2'b00};
                cnt_d = cnt_q + 1'b1;
                if (last_step || early) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            q_q      <= '0;
            m_q      <= '0;
            prod_q   <= '0;
            adds_q   <= '0;
            subs_q   <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            m_q      <= m_d;
            prod_q   <= prod_d;
            adds_q   <= adds_d;
            subs_q   <= subs_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
        end
    end

    assign done = (state_q == StIdle);
    assign prod = prod_q;
    assign adds = adds_q;
    assign subs = subs_q;

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Directed bench for booth_radix4_mul (WIDTH=32): vector table plus control corner sequences.
module tb_booth_radix4_mul;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [W-1:0]  mtpr = '0;
    logic [W-1:0]  mtpd = '0;
    logic          done;
    logic [4:0]    adds, subs;
    logic [2*W-1:0] prod;

    int n_tests = 0;
    int n_fail  = 0;

    booth_radix4_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .mtpr        (mtpr),
        .mtpd        (mtpd),
        .done        (done),
        .adds        (adds),
        .subs        (subs),
        .prod        (prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] p;
        int             n_add;
        int             n_sub;
        int             cyc_en;
        int             cyc_no;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for done with a cycle bound; returns RUN cycles seen since the start edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          output int cycles);
        @(negedge clk);
        mtpr = a;
        mtpd = b;
        signed_mode = sgn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(done), 64'd0);
        wait_done(cycles);
    endtask

    initial begin
        int cyc;
        int exp_cyc;

        vecs[0] = '{32'd7,        32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 2, 16};
        vecs[1] = '{32'hFFFF_FFFF, 32'd2,        1'b0, 64'h0000_0001_FFFF_FFFE, 1, 1, 17, 17};
        vecs[2] = '{32'hFFFF_FFFF, 32'd2,        1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 16};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 1, 16, 16};
        vecs[4] = '{32'd0,        32'h1234_5678, 1'b0, 64'd0,                  0, 0, 1, 17};
        vecs[5] = '{32'd3,        32'd5,         1'b0, 64'd15,                 1, 1, 2, 17};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1,                  0, 1, 1, 16};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1, 1, 17, 17};
        vecs[8] = '{32'd2,        32'd3,         1'b0, 64'd6,                  1, 1, 2, 17};

        // Reset state, asserted from time 0.
        #12;
        check("reset_done", 64'(done), 64'd1);
        check("reset_prod", prod, 64'd0);
        check("reset_adds", 64'(adds), 64'd0);
        check("reset_subs", 64'(subs), 64'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_beats_start", 64'(done), 64'd1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
`ifdef BOOTH_EARLY_TERM_EN
            exp_cyc = vecs[i].cyc_en;
`else
            exp_cyc = vecs[i].cyc_no;
`endif
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, cyc);
            check($sformatf("vec%0d_prod", i), prod, vecs[i].p);
            check($sformatf("vec%0d_adds", i), 64'(adds), 64'(vecs[i].n_add));
            check($sformatf("vec%0d_subs", i), 64'(subs), 64'(vecs[i].n_sub));
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(exp_cyc));
        end

        // Start pulse with new operands mid-RUN is ignored.
        @(negedge clk);
        mtpr = 32'h8000_0000;
        mtpd = 32'h8000_0000;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mtpr = 32'd3;
        mtpd = 32'd5;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #6;
        wait_done(cyc);
        check("midrun_start_prod", prod, 64'h4000_0000_0000_0000);
        check("midrun_start_subs", 64'(subs), 64'd1);
        check("midrun_start_adds", 64'(adds), 64'd0);

        // Asynchronous reset mid-RUN clears outputs before the next edge.
        run_op(32'd1, 32'd1, 1'b0, cyc);
        @(negedge clk);
        mtpr = 32'hFFFF_FFFF;
        mtpd = 32'd2;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_busy", 64'(done), 64'd0);
        rst = 1'b1;
        #1;
        check("midrun_rst_done", 64'(done), 64'd1);
        check("midrun_rst_prod", prod, 64'd0);
        check("midrun_rst_subs", 64'(subs), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd3, 32'd5, 1'b0, cyc);
        check("post_rst_prod", prod, 64'd15);

        // Start held high: the next op begins on the edge after done rises.
        @(negedge clk);
        mtpr = 32'd7;
        mtpd = 32'hFFFF_FFFD;
        signed_mode = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(cyc);
        check("b2b_first_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);
        mtpr = 32'd2;
        mtpd = 32'd3;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_restart_busy", 64'(done), 64'd0);
        start = 1'b0;
        wait_done(cyc);
        check("b2b_second_prod", prod, 64'd6);
        check("b2b_second_done", 64'(done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
